// File: rtl/circle_pkg.sv
// Shared types and helpers for the circle engine and related framebuffer drawers.
package circle_pkg;

  typedef enum logic [1:0] {StIdle, StInit, StPlot, StDone} state_t;

  typedef logic [2:0] oct_t;

  localparam int ScreenWDefault = 160;
  localparam int ScreenHDefault = 120;

  // Signed coordinate width wide enough that centre +/- radius never wraps.
  function automatic int coord_w(input int xw, input int yw, input int rw);
    int m;
    m = (xw > yw) ? xw : yw;
    if (rw > m) m = rw;
    return m + 2;
  endfunction

  function automatic logic in_screen(input int x, input int y, input int w, input int h);
    return (x >= 0) && (x < w) && (y >= 0) && (y < h);
  endfunction

endpackage

// File: rtl/circle_octant_mux.sv
// Combinational octant selector: maps (cx, cy, ox, oy, oct) to a candidate pixel and clip flag.
module circle_octant_mux
  import circle_pkg::*;
#(
  parameter int SCREEN_W = ScreenWDefault,
  parameter int SCREEN_H = ScreenHDefault,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int RADIUS_W = 8,
  localparam int CW      = coord_w(X_W, Y_W, RADIUS_W)
) (
  input  logic [X_W-1:0]       cx,
  input  logic [Y_W-1:0]       cy,
  input  logic signed [CW-1:0] ox,
  input  logic signed [CW-1:0] oy,
  input  oct_t                 oct,
  output logic [X_W-1:0]       px,
  output logic [Y_W-1:0]       py,
  output logic                 in_bounds
);

  logic signed [CW-1:0] cx_s, cy_s, x, y;

  assign cx_s = signed'(CW'(cx));
  assign cy_s = signed'(CW'(cy));

  always_comb begin
    x = cx_s;
    y = cy_s;
    case (oct)
      3'd0: begin x = cx_s + ox; y = cy_s + oy; end
      3'd1: begin x = cx_s + oy; y = cy_s + ox; end
      3'd2: begin x = cx_s - ox; y = cy_s + oy; end
      3'd3: begin x = cx_s - oy; y = cy_s + ox; end
      3'd4: begin x = cx_s - ox; y = cy_s - oy; end
      3'd5: begin x = cx_s - oy; y = cy_s - ox; end
      3'd6: begin x = cx_s + ox; y = cy_s - oy; end
      3'd7: begin x = cx_s + oy; y = cy_s - ox; end
      default: ;
    endcase
  end

  assign px        = x[X_W-1:0];
  assign py        = y[Y_W-1:0];
  assign in_bounds = in_screen(int'(x), int'(y), SCREEN_W, SCREEN_H);

endmodule

// File: rtl/circle_engine.sv
// Midpoint circle drawer with start/done handshake, one pixel per cycle to the VGA adaptor.
// Define CIRCLE_FILL_EN to draw a filled disc as horizontal spans instead of the outline.
module circle_engine
  import circle_pkg::*;
#(
  parameter int SCREEN_W = ScreenWDefault,
  parameter int SCREEN_H = ScreenHDefault,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int RADIUS_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [X_W-1:0]      centre_x,
  input  logic [Y_W-1:0]      centre_y,
  input  logic [RADIUS_W-1:0] radius,
  input  logic [COLOUR_W-1:0] colour,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam int CW     = coord_w(X_W, Y_W, RADIUS_W);
  localparam int CRIT_W = RADIUS_W + 3;

  state_t state_q, state_d;
  logic [X_W-1:0]      cx_q, cx_d;
  logic [Y_W-1:0]      cy_q, cy_d;
  logic [RADIUS_W-1:0] radius_q, radius_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic signed [CW-1:0]     ox_q, ox_d, oy_q, oy_d;
  logic signed [CRIT_W-1:0] crit_q, crit_d;
  oct_t                oct_q, oct_d;
  logic [X_W-1:0]      last_x_q;
  logic [Y_W-1:0]      last_y_q;

  // Midpoint step, evaluated every cycle and committed only at the end of an iteration.
  logic signed [CW-1:0]     oy_n, ox_n, r_ext;
  logic signed [CRIT_W-1:0] crit_inc, crit_n;
  logic                     crit_le0, last_iter;

  always_comb begin
    r_ext    = signed'(CW'(radius_q));
    crit_le0 = crit_q[CRIT_W-1] || (crit_q == '0);
    oy_n     = oy_q + CW'(1);
    ox_n     = crit_le0 ? ox_q : ox_q - CW'(1);
    crit_inc = crit_le0 ? CRIT_W'(oy_n) : CRIT_W'(oy_n - ox_n);
    crit_n   = crit_q + (crit_inc <<< 1) + CRIT_W'(1);
    last_iter = oy_n > ox_n;
  end

  logic signed [CW-1:0] mux_ox, mux_oy;
  oct_t                 mux_oct;
  logic [X_W-1:0]       px;
  logic [Y_W-1:0]       py;
  logic                 in_bounds;

`ifdef CIRCLE_FILL_EN
  // dx_q walks the span as an offset from cx; oct_q numbers the four spans.
  logic signed [CW-1:0] dx_q, dx_d, half;

  always_comb begin
    half    = oct_q[1] ? oy_q : ox_q;
    mux_ox  = dx_q;
    mux_oct = 3'd0;
    case (oct_q[1:0])
      2'd0:    mux_oy = oy_q;
      2'd1:    mux_oy = -oy_q;
      2'd2:    mux_oy = ox_q;
      default: mux_oy = -ox_q;
    endcase
  end
`else
  always_comb begin
    mux_ox  = ox_q;
    mux_oy  = oy_q;
    mux_oct = oct_q;
  end
`endif

  circle_octant_mux #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .RADIUS_W (RADIUS_W)
  ) u_octant_mux (
    .cx        (cx_q),
    .cy        (cy_q),
    .ox        (mux_ox),
    .oy        (mux_oy),
    .oct       (mux_oct),
    .px        (px),
    .py        (py),
    .in_bounds (in_bounds)
  );

  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    radius_d = radius_q;
    colour_d = colour_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    crit_d   = crit_q;
    oct_d    = oct_q;
`ifdef CIRCLE_FILL_EN
    dx_d     = dx_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cx_d     = centre_x;
          cy_d     = centre_y;
          radius_d = radius;
          colour_d = colour;
          state_d  = StInit;
        end
      end
      StInit: begin
        ox_d    = r_ext;
        oy_d    = '0;
        crit_d  = CRIT_W'(1) - CRIT_W'(r_ext);
        oct_d   = '0;
`ifdef CIRCLE_FILL_EN
        dx_d    = -r_ext;
`endif
        state_d = StPlot;
      end
      StPlot: begin
`ifdef CIRCLE_FILL_EN
        if (dx_q != half) begin
          dx_d = dx_q + CW'(1);
        end else if (oct_q != 3'd3) begin
          oct_d = oct_q + 3'd1;
          dx_d  = (oct_q == 3'd0) ? -ox_q : -oy_q;
        end else begin
          ox_d    = ox_n;
          oy_d    = oy_n;
          crit_d  = crit_n;
          oct_d   = '0;
          dx_d    = -ox_n;
          state_d = last_iter ? StDone : StPlot;
        end
`else
        if (oct_q == 3'd7) begin
          ox_d    = ox_n;
          oy_d    = oy_n;
          crit_d  = crit_n;
          oct_d   = '0;
          state_d = last_iter ? StDone : StPlot;
        end else begin
          oct_d = oct_q + 3'd1;
        end
`endif
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cx_q     <= '0;
      cy_q     <= '0;
      radius_q <= '0;
      colour_q <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      crit_q   <= '0;
      oct_q    <= '0;
      last_x_q <= '0;
      last_y_q <= '0;
`ifdef CIRCLE_FILL_EN
      dx_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      radius_q <= radius_d;
      colour_q <= colour_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      crit_q   <= crit_d;
      oct_q    <= oct_d;
`ifdef CIRCLE_FILL_EN
      dx_q     <= dx_d;
`endif
      if (state_q == StPlot) begin
        last_x_q <= px;
        last_y_q <= py;
      end
    end
  end

  // Outside PLOT the coordinates hold the last candidate so the adaptor bus stays quiet.
  always_comb begin
    vga_plot   = (state_q == StPlot) && in_bounds;
    vga_x      = (state_q == StPlot) ? px : last_x_q;
    vga_y      = (state_q == StPlot) ? py : last_y_q;
    vga_colour = colour_q;
    done       = (state_q == StDone);
  end

endmodule

// File: tb/tb_circle_engine.sv
// Scoreboard bench for circle_engine (outline build): expected pixels queued per draw, popped per cycle.
module tb_circle_engine;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] radius;
  logic [2:0] colour;
  logic       done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  circle_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .centre_x   (centre_x),
    .centre_y   (centre_y),
    .radius     (radius),
    .colour     (colour),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic       p;
  } pix_t;

  int         checks = 0;
  int         errors = 0;
  pix_t       exp_q[$];
  logic [7:0] obs_x[$];
  logic [6:0] obs_y[$];
  logic       obs_p[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference midpoint circle: eight octant candidates per iteration, clipped to 160x120.
  function automatic void model_push(input int cx, input int cy, input int r);
    int   ox = r;
    int   oy = 0;
    int   crit = 1 - r;
    int   px, py;
    pix_t e;
    do begin
      for (int o = 0; o < 8; o++) begin
        case (o)
          0: begin px = cx + ox; py = cy + oy; end
          1: begin px = cx + oy; py = cy + ox; end
          2: begin px = cx - ox; py = cy + oy; end
          3: begin px = cx - oy; py = cy + ox; end
          4: begin px = cx - ox; py = cy - oy; end
          5: begin px = cx - oy; py = cy - ox; end
          6: begin px = cx + ox; py = cy - oy; end
          default: begin px = cx + oy; py = cy - ox; end
        endcase
        e.x = 8'(px);
        e.y = 7'(py);
        e.p = (px >= 0) && (px < 160) && (py >= 0) && (py < 120);
        exp_q.push_back(e);
      end
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
  endfunction

  // Leaves the DUT in DONE with start still high.
  task automatic run_draw(input int cx, input int cy, input int r, input logic [2:0] col,
                          input string name);
    pix_t e;
    exp_q.delete();
    obs_x.delete();
    obs_y.delete();
    obs_p.delete();
    model_push(cx, cy, r);
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    radius   = 8'(r);
    colour   = col;
    start    = 1'b1;
    tick;
    centre_x = 8'($urandom);
    centre_y = 7'($urandom);
    radius   = 8'($urandom);
    colour   = 3'($urandom);
    checks++;
    if (vga_plot !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s init: plot=%b done=%b required plot=0 done=0", name, vga_plot, done);
    end
    tick;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      obs_x.push_back(vga_x);
      obs_y.push_back(vga_y);
      obs_p.push_back(vga_plot);
      checks++;
      if (vga_plot !== e.p || vga_x !== e.x || vga_y !== e.y || vga_colour !== col ||
          done !== 1'b0) begin
        errors++;
        $display("FAIL %s pixel %0d: got (%0d,%0d) plot=%b col=%0d done=%b required (%0d,%0d) plot=%b col=%0d done=0",
                 name, obs_x.size(), vga_x, vga_y, vga_plot, vga_colour, done,
                 e.x, e.y, e.p, col);
      end
      tick;
    end
    checks++;
    if (done !== 1'b1 || vga_plot !== 1'b0) begin
      errors++;
      $display("FAIL %s end: done=%b plot=%b required done=1 plot=0", name, done, vga_plot);
    end
  endtask

  task automatic finish_draw(input string name);
    start = 1'b0;
    tick;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s release: done=%b required 0", name, done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    centre_x = '0;
    centre_y = '0;
    radius = '0;
    colour = '0;
    tick;
    tick;
    checks++;
    if (done !== 1'b0 || vga_plot !== 1'b0 || vga_x !== 8'd0 || vga_y !== 7'd0 ||
        vga_colour !== 3'd0) begin
      errors++;
      $display("FAIL reset: done=%b plot=%b x=%0d y=%0d col=%0d required all 0",
               done, vga_plot, vga_x, vga_y, vga_colour);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset_mid_draw;
    int bad = 0;
    centre_x = 8'd80;
    centre_y = 7'd60;
    radius   = 8'd40;
    colour   = 3'd5;
    start    = 1'b1;
    tick;
    tick;
    repeat (19) tick;
    checks++;
    if (vga_plot !== 1'b1) begin
      errors++;
      $display("FAIL mid_draw plotting before reset: plot=%b required 1", vga_plot);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (vga_plot !== 1'b0 || done !== 1'b0 || vga_x !== 8'd0 || vga_y !== 7'd0 ||
        vga_colour !== 3'd0) begin
      errors++;
      $display("FAIL mid_draw async reset: plot=%b done=%b x=%0d y=%0d col=%0d required all 0",
               vga_plot, done, vga_x, vga_y, vga_colour);
    end
    start = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    repeat (30) begin
      tick;
      if (vga_plot !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_draw quiet after reset: %0d active cycles required 0", bad);
    end
    run_draw(20, 20, 5, 3'd1, "after_reset");
    finish_draw("after_reset");
  endtask

  task automatic test_circle_r40;
    int bad = 0;
    int d;
    run_draw(80, 60, 40, 3'd2, "r40");
    checks++;
    if (obs_x[0] !== 8'd120 || obs_y[0] !== 7'd60 || obs_p[0] !== 1'b1) begin
      errors++;
      $display("FAIL r40 first: got (%0d,%0d) plot=%b required (120,60) plot=1",
               obs_x[0], obs_y[0], obs_p[0]);
    end
    checks++;
    if (obs_x[1] !== 8'd80 || obs_y[1] !== 7'd100 || obs_p[1] !== 1'b1) begin
      errors++;
      $display("FAIL r40 second: got (%0d,%0d) plot=%b required (80,100) plot=1",
               obs_x[1], obs_y[1], obs_p[1]);
    end
    foreach (obs_x[i]) begin
      if (obs_p[i]) begin
        d = (int'(obs_x[i]) - 80) * (int'(obs_x[i]) - 80) +
            (int'(obs_y[i]) - 60) * (int'(obs_y[i]) - 60) - 1600;
        if (d > 80 || d < -80) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL r40 on_circle: %0d points off circle required 0", bad);
    end
    finish_draw("r40");
  endtask

  task automatic test_r0;
    int bad = 0;
    run_draw(10, 10, 0, 3'd3, "r0");
    foreach (obs_x[i]) if (obs_x[i] !== 8'd10 || obs_y[i] !== 7'd10) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL r0 points: %0d not at (10,10) required 0", bad);
    end
    finish_draw("r0");
  endtask

  task automatic test_r1;
    int bad = 0;
    run_draw(50, 50, 1, 3'd5, "r1");
    for (int i = 8; i < 16; i++) begin
      if (!((obs_x[i] == 8'd49 || obs_x[i] == 8'd51) &&
            (obs_y[i] == 7'd49 || obs_y[i] == 7'd51))) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL r1 diagonals: %0d of cycles 9-16 off diagonal required 0", bad);
    end
    finish_draw("r1");
  endtask

  task automatic test_clip;
    int bad = 0;
    run_draw(0, 0, 10, 3'd7, "clip");
    checks++;
    if (obs_x[0] !== 8'd10 || obs_y[0] !== 7'd0 || obs_p[0] !== 1'b1) begin
      errors++;
      $display("FAIL clip first: got (%0d,%0d) plot=%b required (10,0) plot=1",
               obs_x[0], obs_y[0], obs_p[0]);
    end
    checks++;
    if (obs_p[2] !== 1'b0) begin
      errors++;
      $display("FAIL clip third: plot=%b required 0", obs_p[2]);
    end
    foreach (obs_x[i]) if (obs_p[i] && (obs_x[i] >= 8'd160 || obs_y[i] >= 7'd120)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clip offscreen: %0d offscreen plots required 0", bad);
    end
    finish_draw("clip");
  endtask

  task automatic test_handshake;
    int bad = 0;
    run_draw(30, 40, 15, 3'd4, "hs_first");
    repeat (6) begin
      tick;
      if (done !== 1'b1 || vga_plot !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hs_hold: %0d cycles left DONE or replotted required 0", bad);
    end
    finish_draw("hs_first");
    run_draw(100, 70, 20, 3'd6, "hs_second");
    finish_draw("hs_second");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_reset_mid_draw();
    test_circle_r40();
    test_r0();
    test_r1();
    test_clip();
    test_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
